// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : RV32I ID/EX pipeline register with load-use hazard detection,
//               bubble insertion, flush handling and a saturating bubble count.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_in,
    input  logic             flush_in,
    input  logic             mem_rd_in,
    input  logic             mem_wr_in,
    input  logic             reg_wr_in,
    input  logic             mux_reg_wr_in,
    input  logic             jump_in,
    input  logic             branch_in,
    input  logic             jalr_in,
    input  logic [1:0]       ula_op_in,
    input  logic [1:0]       alu_src1_in,
    input  logic [1:0]       alu_src2_in,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  rs1_data_in,
    input  logic [XLEN-1:0]  rs2_data_in,
    input  logic [XLEN-1:0]  imm_in,
    input  logic [4:0]       rs1_in,
    input  logic [4:0]       rs2_in,
    input  logic [4:0]       rd_in,
    input  logic [2:0]       funct3_in,
    input  logic             funct7b5_in,
    output logic             mem_rd_out,
    output logic             mem_wr_out,
    output logic             reg_wr_out,
    output logic             mux_reg_wr_out,
    output logic             jump_out,
    output logic             branch_out,
    output logic             jalr_out,
    output logic [1:0]       ula_op_out,
    output logic [1:0]       alu_src1_out,
    output logic [1:0]       alu_src2_out,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  rs1_data_out,
    output logic [XLEN-1:0]  rs2_data_out,
    output logic [XLEN-1:0]  imm_out,
    output logic [4:0]       rs1_out,
    output logic [4:0]       rs2_out,
    output logic [4:0]       rd_out,
    output logic [2:0]       funct3_out,
    output logic             funct7b5_out,
    output logic             ex_valid_out,
    output logic             stall_out,
    output logic [CNT_W-1:0] bubble_cnt_out
);

    // Control word held in EX
    logic             r_mem_rd, r_mem_wr, r_reg_wr, r_mux_reg_wr;
    logic             r_jump, r_branch, r_jalr, r_ex_valid;
    logic [1:0]       r_ula_op, r_alu_src1, r_alu_src2;
    // Datapath fields held in EX
    logic [XLEN-1:0]  r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [4:0]       r_rs1, r_rs2, r_rd;
    logic [2:0]       r_funct3;
    logic             r_funct7b5;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic             w_haz;
    logic             w_bubble;
    logic             w_reg_wr_san;

    // Load-use detection against the load sitting in EX; rs2 is always compared
    always_comb begin
        w_haz        = r_ex_valid & r_mem_rd & (r_rd != 5'd0) & id_valid_in &
                       ((r_rd == rs1_in) | (r_rd == rs2_in));
        w_bubble     = flush_in | w_haz;
        w_reg_wr_san = reg_wr_in & ~branch_in & ~mem_wr_in &
                       (rd_in != 5'd0) & id_valid_in;
    end

    // Control capture: flush or hazard inserts a bubble, otherwise load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_reg_wr     <= 1'b0;
            r_mux_reg_wr <= 1'b0;
            r_jump       <= 1'b0;
            r_branch     <= 1'b0;
            r_jalr       <= 1'b0;
            r_ula_op     <= 2'b00;
            r_alu_src1   <= 2'b00;
            r_alu_src2   <= 2'b00;
            r_ex_valid   <= 1'b0;
        end else if (w_bubble || !id_valid_in) begin
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_reg_wr     <= 1'b0;
            r_mux_reg_wr <= 1'b0;
            r_jump       <= 1'b0;
            r_branch     <= 1'b0;
            r_jalr       <= 1'b0;
            r_ula_op     <= 2'b00;
            r_alu_src1   <= 2'b00;
            r_alu_src2   <= 2'b00;
            r_ex_valid   <= 1'b0;
        end else begin
            r_mem_rd     <= mem_rd_in;
            r_mem_wr     <= mem_wr_in;
            r_reg_wr     <= w_reg_wr_san;
            r_mux_reg_wr <= mux_reg_wr_in;
            r_jump       <= jump_in;
            r_branch     <= branch_in;
            r_jalr       <= jalr_in;
            r_ula_op     <= ula_op_in;
            r_alu_src1   <= alu_src1_in;
            r_alu_src2   <= alu_src2_in;
            r_ex_valid   <= 1'b1;
        end
    end

    // Datapath fields load every edge; they are meaningless while EX is invalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_funct3   <= 3'd0;
            r_funct7b5 <= 1'b0;
        end else begin
            r_pc       <= pc_in;
            r_rs1_data <= rs1_data_in;
            r_rs2_data <= rs2_data_in;
            r_imm      <= imm_in;
            r_rs1      <= rs1_in;
            r_rs2      <= rs2_in;
            r_rd       <= rd_in;
            r_funct3   <= funct3_in;
            r_funct7b5 <= funct7b5_in;
        end
    end

    // Count hazard bubbles only (a flush takes precedence and is not counted)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_haz && !flush_in && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign mem_rd_out     = r_mem_rd;
    assign mem_wr_out     = r_mem_wr;
    assign reg_wr_out     = r_reg_wr;
    assign mux_reg_wr_out = r_mux_reg_wr;
    assign jump_out       = r_jump;
    assign branch_out     = r_branch;
    assign jalr_out       = r_jalr;
    assign ula_op_out     = r_ula_op;
    assign alu_src1_out   = r_alu_src1;
    assign alu_src2_out   = r_alu_src2;
    assign pc_out         = r_pc;
    assign rs1_data_out   = r_rs1_data;
    assign rs2_data_out   = r_rs2_data;
    assign imm_out        = r_imm;
    assign rs1_out        = r_rs1;
    assign rs2_out        = r_rs2;
    assign rd_out         = r_rd;
    assign funct3_out     = r_funct3;
    assign funct7b5_out   = r_funct7b5;
    assign ex_valid_out   = r_ex_valid;
    assign stall_out      = w_haz & ~flush_in;
    assign bubble_cnt_out = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage (CNT_W = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk, rst_n;
    logic             id_valid_in, flush_in;
    logic             mem_rd_in, mem_wr_in, reg_wr_in, mux_reg_wr_in;
    logic             jump_in, branch_in, jalr_in;
    logic [1:0]       ula_op_in, alu_src1_in, alu_src2_in;
    logic [XLEN-1:0]  pc_in, rs1_data_in, rs2_data_in, imm_in;
    logic [4:0]       rs1_in, rs2_in, rd_in;
    logic [2:0]       funct3_in;
    logic             funct7b5_in;
    logic             mem_rd_out, mem_wr_out, reg_wr_out, mux_reg_wr_out;
    logic             jump_out, branch_out, jalr_out;
    logic [1:0]       ula_op_out, alu_src1_out, alu_src2_out;
    logic [XLEN-1:0]  pc_out, rs1_data_out, rs2_data_out, imm_out;
    logic [4:0]       rs1_out, rs2_out, rd_out;
    logic [2:0]       funct3_out;
    logic             funct7b5_out;
    logic             ex_valid_out, stall_out;
    logic [CNT_W-1:0] bubble_cnt_out;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid_in(id_valid_in), .flush_in(flush_in),
        .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in), .reg_wr_in(reg_wr_in),
        .mux_reg_wr_in(mux_reg_wr_in), .jump_in(jump_in), .branch_in(branch_in),
        .jalr_in(jalr_in), .ula_op_in(ula_op_in), .alu_src1_in(alu_src1_in),
        .alu_src2_in(alu_src2_in), .pc_in(pc_in), .rs1_data_in(rs1_data_in),
        .rs2_data_in(rs2_data_in), .imm_in(imm_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
        .rd_in(rd_in), .funct3_in(funct3_in), .funct7b5_in(funct7b5_in),
        .mem_rd_out(mem_rd_out), .mem_wr_out(mem_wr_out), .reg_wr_out(reg_wr_out),
        .mux_reg_wr_out(mux_reg_wr_out), .jump_out(jump_out), .branch_out(branch_out),
        .jalr_out(jalr_out), .ula_op_out(ula_op_out), .alu_src1_out(alu_src1_out),
        .alu_src2_out(alu_src2_out), .pc_out(pc_out), .rs1_data_out(rs1_data_out),
        .rs2_data_out(rs2_data_out), .imm_out(imm_out), .rs1_out(rs1_out),
        .rs2_out(rs2_out), .rd_out(rd_out), .funct3_out(funct3_out),
        .funct7b5_out(funct7b5_out), .ex_valid_out(ex_valid_out),
        .stall_out(stall_out), .bubble_cnt_out(bubble_cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a new ID instruction with a compact set of fields; others cleared
    task automatic present(input logic v, input logic mrd, input logic mwr, input logic rwr,
                           input logic br, input logic [1:0] op,
                           input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        id_valid_in   = v;
        mem_rd_in     = mrd;
        mem_wr_in     = mwr;
        reg_wr_in     = rwr;
        mux_reg_wr_in = mrd;
        branch_in     = br;
        jump_in       = 1'b0;
        jalr_in       = 1'b0;
        ula_op_in     = op;
        alu_src1_in   = 2'b00;
        alu_src2_in   = {1'b0, mrd | mwr};
        rd_in         = rd;
        rs1_in        = s1;
        rs2_in        = s2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush_in = 1'b0;
        present(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
        pc_in = 32'h100; rs1_data_in = 32'h11; rs2_data_in = 32'h22;
        imm_in = 32'h4; funct3_in = 3'd0; funct7b5_in = 1'b0;
        #12;
        check("rst_ex_valid", 64'(ex_valid_out), 64'd0);
        check("rst_cnt", 64'(bubble_cnt_out), 64'd0);
        check("rst_pc", 64'(pc_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type pass-through
        present(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 5'd5, 5'd1, 5'd2);
        funct3_in = 3'd5; funct7b5_in = 1'b1;
        tick();
        check("rtype_reg_wr", 64'(reg_wr_out), 64'd1);
        check("rtype_ula_op", 64'(ula_op_out), 64'd2);
        check("rtype_rd", 64'(rd_out), 64'd5);
        check("rtype_rs1_data", 64'(rs1_data_out), 64'h11);
        check("rtype_rs2_data", 64'(rs2_data_out), 64'h22);
        check("rtype_pc", 64'(pc_out), 64'h100);
        check("rtype_f3f7", 64'({funct3_out, funct7b5_out}), 64'hB);
        check("rtype_valid", 64'(ex_valid_out), 64'd1);
        check("rtype_stall", 64'(stall_out), 64'd0);

        // Branch never writes the register file
        present(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 5'd3, 5'd1, 5'd2);
        tick();
        check("br_reg_wr", 64'(reg_wr_out), 64'd0);
        check("br_branch", 64'(branch_out), 64'd1);

        // addi to x0 never writes
        present(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 5'd1, 5'd0);
        tick();
        check("x0_reg_wr", 64'(reg_wr_out), 64'd0);
        check("x0_valid", 64'(ex_valid_out), 64'd1);

        // Store with reg_wr set never writes
        present(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 5'd6, 5'd1, 5'd2);
        tick();
        check("sw_reg_wr", 64'(reg_wr_out), 64'd0);
        check("sw_mem_wr", 64'(mem_wr_out), 64'd1);

        // Invalid ID slot loads a clean bubble
        present(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 5'd9, 5'd1, 5'd2);
        tick();
        check("inv_valid", 64'(ex_valid_out), 64'd0);
        check("inv_ctl", 64'({mem_rd_out, reg_wr_out, ula_op_out}), 64'd0);

        // Load-use on rs1: lw x7 ; add x8,x7,x1
        present(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 5'd7, 5'd2, 5'd0);
        tick();
        check("lw_mem_rd", 64'(mem_rd_out), 64'd1);
        present(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 5'd8, 5'd7, 5'd1);
        #1;
        check("lu_stall", 64'(stall_out), 64'd1);
        tick();
        check("lu_bub_valid", 64'(ex_valid_out), 64'd0);
        check("lu_bub_ctl", 64'({mem_rd_out, reg_wr_out, mux_reg_wr_out, ula_op_out}), 64'd0);
        check("lu_cnt", 64'(bubble_cnt_out), 64'd1);
        check("lu_stall_off", 64'(stall_out), 64'd0);
        tick();
        check("lu_add_valid", 64'(ex_valid_out), 64'd1);
        check("lu_add_rd", 64'(rd_out), 64'd8);
        check("lu_add_reg_wr", 64'(reg_wr_out), 64'd1);
        check("lu_cnt_hold", 64'(bubble_cnt_out), 64'd1);

        // Load-use on rs2: lw x9 ; sw x9,0(x1)
        present(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 5'd9, 5'd2, 5'd0);
        tick();
        present(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 5'd1, 5'd9);
        #1;
        check("lu2_stall", 64'(stall_out), 64'd1);
        tick();
        check("lu2_cnt", 64'(bubble_cnt_out), 64'd2);

        // Flush beats hazard: no stall, bubble, no count
        present(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 5'd7, 5'd2, 5'd0);
        tick();
        present(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 5'd8, 5'd7, 5'd1);
        flush_in = 1'b1;
        #1;
        check("fl_stall", 64'(stall_out), 64'd0);
        tick();
        flush_in = 1'b0;
        check("fl_valid", 64'(ex_valid_out), 64'd0);
        check("fl_ctl", 64'({reg_wr_out, ula_op_out}), 64'd0);
        check("fl_cnt", 64'(bubble_cnt_out), 64'd2);

        // 17 more hazard bubbles: 2 + 17 saturates at 15
        for (int i = 0; i < 17; i++) begin
            present(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 5'd7, 5'd2, 5'd0);
            tick();
            present(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 5'd8, 5'd7, 5'd1);
            tick();
            if (i == 12) check("sat_mid", 64'(bubble_cnt_out), 64'd15);
        end
        check("sat_cnt", 64'(bubble_cnt_out), 64'd15);

        // Reset in the middle of a stall
        present(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 5'd7, 5'd2, 5'd0);
        tick();
        present(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 5'd8, 5'd7, 5'd1);
        #1;
        check("mid_stall", 64'(stall_out), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 64'(stall_out), 64'd0);
        check("mid_rst_valid", 64'(ex_valid_out), 64'd0);
        check("mid_rst_ctl", 64'({mem_rd_out, reg_wr_out, mux_reg_wr_out}), 64'd0);
        check("mid_rst_cnt", 64'(bubble_cnt_out), 64'd0);
        check("mid_rst_dp", 64'({rd_out, rs1_out, pc_out}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the RV32I 5-stage pipeline.
- Captures the decoder control word, operands, immediate and register indices at the end of ID and presents them to EX.
- Detects load-use hazards, requests an IF/ID stall and inserts a bubble.
- Kills the ID instruction on a branch/jump flush from EX.
- Keeps a saturating count of inserted hazard bubbles.

Parameters:
- XLEN, 32, datapath width of pc, operand and immediate fields.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid_in  in  1  ID holds a real instruction.
- flush_in  in  1  taken branch/jump resolved in EX; kill the ID instruction.
- mem_rd_in, mem_wr_in, reg_wr_in, mux_reg_wr_in  in  1 each  decoder MEM/WB controls.
- jump_in, branch_in, jalr_in  in  1 each  decoder ID controls.
- ula_op_in, alu_src1_in, alu_src2_in  in  2 each  decoder EX controls.
- pc_in, rs1_data_in, rs2_data_in, imm_in  in  XLEN each  ID datapath.
- rs1_in, rs2_in, rd_in  in  5 each  register indices.
- funct3_in  in  3  instruction funct3.
- funct7b5_in  in  1  instruction bit 30.
- *_out counterparts of every control and datapath input above  out  same widths  registered EX-side copies.
- ex_valid_out  out  1  EX holds a real instruction.
- stall_out  out  1  combinational; freeze PC and IF/ID this cycle.
- bubble_cnt_out  out  CNT_W  saturating count of hazard bubbles.

Behaviour:
- Reset (rst_n=0, asynchronous): all control outputs, ex_valid_out and bubble_cnt_out go to 0. Datapath outputs (pc, data, imm, indices, funct) also go to 0.
- Control sanitising at capture:
  - reg_wr_out <= reg_wr_in & ~branch_in & ~mem_wr_in & (rd_in != 0) & id_valid_in.
  - Stores and branches therefore never write the register file, and x0 is never written.
- Hazard:
  - haz = ex_valid_out & mem_rd_out & (rd_out != 0) & id_valid_in & ((rd_out == rs1_in) | (rd_out == rs2_in)).
  - rs2 is compared for every opcode; this is conservative by design.
  - stall_out = haz & ~flush_in.
- Each rising edge, priority order:
  - flush_in = 1: bubble. All control outputs and ex_valid_out <= 0. The counter is not incremented.
  - else haz = 1: bubble, same as above. bubble_cnt_out increments, saturating at all-ones.
  - else: load. Control outputs <= inputs (sanitised reg_wr). ex_valid_out <= id_valid_in.
  - id_valid_in = 0 on a load: all control outputs <= 0.
- Datapath fields (pc, rs1/rs2 data, imm, rs1/rs2/rd, funct3, funct7b5) load unconditionally every non-reset edge, including bubbles; they are don't-care while ex_valid_out = 0.
- Latency: 1 cycle from ID inputs to outputs. A load-use pair costs exactly one bubble. The stalled ID instruction re-presents itself the next cycle, and haz then deasserts because EX holds the bubble.
- Simultaneous flush and hazard: flush wins, stall_out = 0, no count.
- Back-to-back loads to the same rd: each dependent consumer gets its own single bubble.
- Reset mid-stall: stall_out drops immediately because ex_valid_out is 0.

Test Plan:
- Reset: pulse rst_n low mid-cycle with arbitrary inputs -> all outputs 0 asynchronously; bubble_cnt_out = 0.
- Normal pass-through: R-type (reg_wr=1, ula_op=10, rd=5, rs1_data=0x11, rs2_data=0x22) -> next edge outputs match, ex_valid_out=1, stall_out=0.
- Sanitising: branch with reg_wr_in=1, rd=3 -> reg_wr_out=0, branch_out=1. Separately, addi to rd=0 -> reg_wr_out=0.
- Load-use hazard: lw x7 then add x8,x7,x1 -> on cycle 2 stall_out=1. On the next edge all EX controls are 0 with ex_valid_out=0 and bubble_cnt_out=1. On the following edge the add is loaded with stall_out=0.
- Flush vs hazard: same lw/add pair with flush_in=1 on cycle 2 -> stall_out=0, bubble inserted, bubble_cnt_out unchanged.
- Counter saturation (CNT_W=4): force 17 hazard bubbles -> bubble_cnt_out holds at 15.
